// File: rtl/csr_pkg.sv
// Shared Zicsr encodings, CSR addresses and sequencer state for the CSR access unit.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_W = 2'b01,
    CSR_OP_S = 2'b10,
    CSR_OP_C = 2'b11
  } csr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_STALL_WAIT,
    ST_RESP
  } csr_state_t;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_ADDR_STATUS   = 12'hFC1;
  localparam logic [11:0] CSR_ADDR_STATS_EN = 12'h7C1;
  localparam logic [11:0] CSR_ADDR_MGR_RX   = 12'hFC0;
  localparam logic [11:0] CSR_ADDR_MGR_TX   = 12'h7C0;

  // funct3 000 and 100 carry no CSR operation.
  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

  function automatic csr_op_t decode_op(input logic [2:0] f3);
    case (f3[1:0])
      2'b10:   return CSR_OP_S;
      2'b11:   return CSR_OP_C;
      default: return CSR_OP_W;
    endcase
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write value for a CSR op; purely combinational.
module csr_alu
  import csr_pkg::*;
(
  input  csr_op_t     op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  output logic [31:0] new_val
);

  always_comb begin
    new_val = src;
    case (op)
      CSR_OP_S: new_val = old_val | src;
      CSR_OP_C: new_val = old_val & ~src;
      default:  new_val = src;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction into registered CSR read/write requests, 5 cycles accept-to-Done for RW.
// Holds Busy until Done; CSR file stalls are retried, optionally bounded by MAX_RETRIES.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 0,
  parameter int unsigned RETRY_W     = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Rs1_Data,
  input  logic [4:0]  Rs1_Field,
  input  logic [4:0]  Rd_Addr_In,
  input  logic [11:0] Instr_CSR_Addr,
  output logic        Busy,
  output logic        CSR_Read,
  output logic        CSR_Write,
  output logic [11:0] CSR_Address,
  output logic [31:0] CSR_Wr_Data,
  input  logic [31:0] CSR_Rd_Data,
  input  logic        Stall,
  output logic        Rd_Wr_En,
  output logic [4:0]  Rd_Addr,
  output logic [31:0] Rd_Data,
  output logic        Done,
  output logic        Illegal,
  output logic        Timeout
);

  csr_state_t         state;
  csr_op_t            op_q;
  logic [31:0]        src_q;
  logic [31:0]        old_q;
  logic               need_read_q;
  logic               need_write_q;
  logic               ret_wr_q;
  logic [RETRY_W-1:0] retry_cnt;

  csr_op_t     op_in;
  logic [31:0] src_in;
  logic        need_read_in;
  logic        need_write_in;
  logic        retry_exceeded;

  assign op_in         = decode_op(Funct3);
  assign src_in        = Funct3[2] ? {27'd0, Rs1_Field} : Rs1_Data;
  assign need_read_in  = !(op_in == CSR_OP_W && Rd_Addr_In == 5'd0);
  assign need_write_in = (op_in == CSR_OP_W) || (Rs1_Field != 5'd0);
  assign retry_exceeded = (MAX_RETRIES != 0) && (retry_cnt > RETRY_W'(MAX_RETRIES));

  // In IDLE the ALU sees the raw instruction so a write-only op can issue on the accept edge;
  // in RD_WAIT it sees the read data arriving this cycle.
  csr_op_t     alu_op;
  logic [31:0] alu_src;
  logic [31:0] alu_old;
  logic [31:0] alu_new;

  assign alu_op  = (state == ST_IDLE) ? op_in : op_q;
  assign alu_src = (state == ST_IDLE) ? src_in : src_q;
  assign alu_old = (state == ST_RD_WAIT) ? CSR_Rd_Data : old_q;

  csr_alu u_alu (
    .op      (alu_op),
    .old_val (alu_old),
    .src     (alu_src),
    .new_val (alu_new)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ST_IDLE;
      op_q         <= CSR_OP_W;
      src_q        <= '0;
      old_q        <= '0;
      need_read_q  <= 1'b0;
      need_write_q <= 1'b0;
      ret_wr_q     <= 1'b0;
      retry_cnt    <= '0;
      Busy         <= 1'b0;
      CSR_Read     <= 1'b0;
      CSR_Write    <= 1'b0;
      CSR_Address  <= '0;
      CSR_Wr_Data  <= '0;
      Rd_Wr_En     <= 1'b0;
      Rd_Addr      <= '0;
      Rd_Data      <= '0;
      Done         <= 1'b0;
      Illegal      <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      CSR_Read    <= 1'b0;
      CSR_Write   <= 1'b0;
      CSR_Wr_Data <= '0;
      Rd_Wr_En    <= 1'b0;
      Rd_Data     <= '0;
      Done        <= 1'b0;
      Illegal     <= 1'b0;
      Timeout     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (Valid) begin
            op_q         <= op_in;
            src_q        <= src_in;
            old_q        <= '0;
            need_read_q  <= need_read_in;
            need_write_q <= need_write_in;
            ret_wr_q     <= 1'b0;
            retry_cnt    <= '0;
            Rd_Addr      <= Rd_Addr_In;
            CSR_Address  <= Instr_CSR_Addr;
            Busy         <= 1'b1;
            if (is_illegal(Funct3)) begin
              state   <= ST_RESP;
              Done    <= 1'b1;
              Illegal <= 1'b1;
            end else if (need_read_in) begin
              state    <= ST_RD_REQ;
              CSR_Read <= 1'b1;
            end else begin
              state       <= ST_WR_REQ;
              CSR_Write   <= 1'b1;
              CSR_Wr_Data <= alu_new;
            end
          end
        end

        ST_RD_REQ: state <= ST_RD_WAIT;

        ST_RD_WAIT: begin
          if (Stall) begin
            state    <= ST_STALL_WAIT;
            ret_wr_q <= 1'b0;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            old_q <= CSR_Rd_Data;
            if (need_write_q) begin
              state       <= ST_WR_REQ;
              CSR_Write   <= 1'b1;
              CSR_Wr_Data <= alu_new;
            end else begin
              state    <= ST_RESP;
              Done     <= 1'b1;
              Rd_Wr_En <= (Rd_Addr != 5'd0);
              Rd_Data  <= CSR_Rd_Data;
            end
          end
        end

        ST_WR_REQ: state <= ST_WR_WAIT;

        ST_WR_WAIT: begin
          if (Stall) begin
            state    <= ST_STALL_WAIT;
            ret_wr_q <= 1'b1;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
          end else begin
            state    <= ST_RESP;
            Done     <= 1'b1;
            Rd_Wr_En <= need_read_q && (Rd_Addr != 5'd0);
            Rd_Data  <= old_q;
          end
        end

        ST_STALL_WAIT: begin
          if (retry_exceeded) begin
            state   <= ST_RESP;
            Done    <= 1'b1;
            Timeout <= 1'b1;
          end else if (!Stall) begin
            if (ret_wr_q) begin
              state       <= ST_WR_REQ;
              CSR_Write   <= 1'b1;
              CSR_Wr_Data <= alu_new;
            end else begin
              state    <= ST_RD_REQ;
              CSR_Read <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          Busy        <= 1'b0;
          CSR_Address <= '0;
          Rd_Addr     <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small behavioural CSR file that stalls on empty RX / full TX.
module tb_csr_access_unit;
  import csr_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, Valid;
  logic [2:0]  Funct3;
  logic [31:0] Rs1_Data;
  logic [4:0]  Rs1_Field, Rd_Addr_In;
  logic [11:0] Instr_CSR_Addr;
  logic        Busy, CSR_Read, CSR_Write;
  logic [11:0] CSR_Address;
  logic [31:0] CSR_Wr_Data, CSR_Rd_Data;
  logic        Stall, Rd_Wr_En, Done, Illegal, Timeout;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;

  csr_access_unit #(.MAX_RETRIES(2), .RETRY_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Valid(Valid), .Funct3(Funct3), .Rs1_Data(Rs1_Data),
    .Rs1_Field(Rs1_Field), .Rd_Addr_In(Rd_Addr_In), .Instr_CSR_Addr(Instr_CSR_Addr),
    .Busy(Busy), .CSR_Read(CSR_Read), .CSR_Write(CSR_Write), .CSR_Address(CSR_Address),
    .CSR_Wr_Data(CSR_Wr_Data), .CSR_Rd_Data(CSR_Rd_Data), .Stall(Stall),
    .Rd_Wr_En(Rd_Wr_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Done(Done),
    .Illegal(Illegal), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // CSR file model state and traffic counters
  logic [31:0] stats_en = 32'd0;
  logic [31:0] rx_q[$];
  bit          host_inject = 1'b0;
  bit          tx_full = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, stall_cnt = 0, done_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_addr = '0;

  initial begin : csr_file
    logic        r, w;
    logic [11:0] a;
    logic [31:0] d;
    Stall = 1'b0;
    CSR_Rd_Data = '0;
    forever begin
      @(negedge Clk);
      r = CSR_Read; w = CSR_Write; a = CSR_Address; d = CSR_Wr_Data;
      if (r) rd_cnt++;
      if (w) begin wr_cnt++; last_wdata = d; end
      if (r && w) both_cnt++;
      if (r || w) last_addr = a;
      if (Done) done_cnt++;
      @(posedge Clk);
      #1;
      Stall = 1'b0;
      if (r && a == CSR_ADDR_MGR_RX) begin
        if (rx_q.size() == 0) begin
          Stall = 1'b1; stall_cnt++;
          if (host_inject) begin rx_q.push_back(32'hDEADBEEF); host_inject = 1'b0; end
        end else CSR_Rd_Data = rx_q.pop_front();
      end else if (r) begin
        CSR_Rd_Data = (a == CSR_ADDR_STATS_EN) ? stats_en : 32'd0;
      end else if (w && a == CSR_ADDR_MGR_TX) begin
        if (tx_full) begin Stall = 1'b1; stall_cnt++; end
      end else if (w && a == CSR_ADDR_STATS_EN) begin
        stats_en = d;
      end
    end
  end

  int          lat;
  bit          found;
  logic        o_wr_en, o_ill, o_to;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  task automatic issue(input logic [2:0] f3, input logic [31:0] rs1d, input logic [4:0] rs1f,
                       input logic [4:0] rd, input logic [11:0] addr);
    @(negedge Clk);
    Funct3 = f3; Rs1_Data = rs1d; Rs1_Field = rs1f; Rd_Addr_In = rd; Instr_CSR_Addr = addr;
    Valid = 1'b1;
    @(posedge Clk);
    #1;
    Valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    lat = 0; found = 1'b0;
    o_wr_en = 1'b0; o_ill = 1'b0; o_to = 1'b0; o_rd_addr = '0; o_rd_data = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      lat++;
      if (Done) begin
        found = 1'b1;
        o_wr_en = Rd_Wr_En; o_ill = Illegal; o_to = Timeout;
        o_rd_addr = Rd_Addr; o_rd_data = Rd_Data;
      end
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  int b_rd, b_wr, b_st, b_dn;
  task automatic snap();
    b_rd = rd_cnt; b_wr = wr_cnt; b_st = stall_cnt; b_dn = done_cnt;
  endtask

  initial begin
    Rst = 1'b1; Valid = 1'b0; Funct3 = '0; Rs1_Data = '0; Rs1_Field = '0;
    Rd_Addr_In = '0; Instr_CSR_Addr = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ctrl", 32'({Busy, CSR_Read, CSR_Write, Done, Rd_Wr_En, Illegal, Timeout}), 32'd0);
    chk("rst_addr", 32'(CSR_Address), 32'd0);
    chk("rst_rd_data", Rd_Data, 32'd0);
    Rst = 1'b0;

    // CSRRW x5, stats_en, x3 (=1): old 0, new 1
    snap();
    issue(F3_CSRRW, 32'd1, 5'd3, 5'd5, CSR_ADDR_STATS_EN);
    wait_done("rw");
    chk("rw_latency", 32'(lat), 32'd5);
    chk("rw_wr_en", 32'(o_wr_en), 32'd1);
    chk("rw_rd_addr", 32'(o_rd_addr), 32'd5);
    chk("rw_rd_data", o_rd_data, 32'd0);
    chk("rw_wdata", last_wdata, 32'h00000001);
    chk("rw_addr", 32'(last_addr), 32'h7C1);
    chk("rw_reads", 32'(rd_cnt - b_rd), 32'd1);
    chk("rw_writes", 32'(wr_cnt - b_wr), 32'd1);
    @(negedge Clk);
    chk("rw_idle_busy", 32'(Busy), 32'd0);

    // CSRRS x6, mgr_rx, x0 on an empty FIFO: one stall, retry reads host word
    host_inject = 1'b1;
    snap();
    issue(F3_CSRRS, 32'hFFFF, 5'd0, 5'd6, CSR_ADDR_MGR_RX);
    wait_done("rx");
    chk("rx_latency", 32'(lat), 32'd6);
    chk("rx_rd_data", o_rd_data, 32'hDEADBEEF);
    chk("rx_wr_en", 32'(o_wr_en), 32'd1);
    chk("rx_rd_addr", 32'(o_rd_addr), 32'd6);
    chk("rx_timeout", 32'(o_to), 32'd0);
    chk("rx_stalls", 32'(stall_cnt - b_st), 32'd1);
    chk("rx_reads", 32'(rd_cnt - b_rd), 32'd2);
    chk("rx_no_write", 32'(wr_cnt - b_wr), 32'd0);

    // CSRRCI x7, stats_en, zimm=1 with stats_en=1: write 0, return 1
    snap();
    issue(F3_CSRRCI, 32'hFFFFFFFF, 5'd1, 5'd7, CSR_ADDR_STATS_EN);
    wait_done("rci");
    chk("rci_latency", 32'(lat), 32'd5);
    chk("rci_wdata", last_wdata, 32'h00000000);
    chk("rci_rd_data", o_rd_data, 32'h00000001);
    chk("rci_wr_en", 32'(o_wr_en), 32'd1);
    chk("rci_csr_after", stats_en, 32'd0);

    // CSRRW x0, mgr_tx on a full FIFO: three stalls then Timeout
    tx_full = 1'b1;
    snap();
    issue(F3_CSRRW, 32'hA5, 5'd2, 5'd0, CSR_ADDR_MGR_TX);
    wait_done("to");
    tx_full = 1'b0;
    chk("to_latency", 32'(lat), 32'd10);
    chk("to_timeout", 32'(o_to), 32'd1);
    chk("to_wr_en", 32'(o_wr_en), 32'd0);
    chk("to_rd_data", o_rd_data, 32'd0);
    chk("to_stalls", 32'(stall_cnt - b_st), 32'd3);
    chk("to_writes", 32'(wr_cnt - b_wr), 32'd3);
    chk("to_no_read", 32'(rd_cnt - b_rd), 32'd0);

    // funct3 100: Illegal, no CSR traffic
    snap();
    issue(3'b100, 32'h1234, 5'd4, 5'd9, CSR_ADDR_STATS_EN);
    wait_done("ill");
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_flag", 32'(o_ill), 32'd1);
    chk("ill_wr_en", 32'(o_wr_en), 32'd0);
    chk("ill_traffic", 32'((rd_cnt - b_rd) + (wr_cnt - b_wr)), 32'd0);

    // Reset while in WR_WAIT aborts the write-only op
    @(negedge Clk);
    snap();
    issue(F3_CSRRW, 32'h55, 5'd1, 5'd0, CSR_ADDR_STATS_EN);
    @(negedge Clk);
    chk("rst_op_wr_req", 32'(CSR_Write), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_op_ctrl", 32'({Busy, CSR_Read, CSR_Write, Done, Rd_Wr_En, Illegal, Timeout}), 32'd0);
    chk("rst_op_addr", 32'(CSR_Address), 32'd0);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);
    chk("rst_op_writes", 32'(wr_cnt - b_wr), 32'd1);
    chk("rst_op_no_done", 32'(done_cnt - b_dn), 32'd0);
    chk("rst_op_busy", 32'(Busy), 32'd0);

    chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
